texture_bc1_enc: RTL and testbench
==================================

# texture_bc1_enc

BC1 (DXT1) block encoder, the write-side counterpart of the texture unit's BC1 decoder (FORMAT=0). It accepts 16 RGBA5652 texels of one 4x4 block as a stream and derives bounding-box endpoints. It then selects a 2-bit palette index per texel and emits the 64-bit block in the same layout the decoder consumes. It sits between render-to-texture / upload logic and the texture memory writer.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `texel_valid`  in  1  texel input valid
- `texel_ready`  out  1  encoder accepts a texel (LOAD state only)
- `texel_rgba5652`  in  18  {R5,G6,B5,A2}; texels arrive row-major, t = y*4+x, t=0 first
- `block_valid`  out  1  encoded block available
- `block_ready`  in  1  downstream accepts block
- `bc1_data`  out  64  [15:0] color0, [31:16] color1, [63:32] indices, texel t at bits [2t+1:2t]

## Operation
- States: LOAD → ENCODE → OUT → LOAD.
- LOAD:
  - Each texel handshake stores the texel in a 16-entry buffer and increments a 4-bit count.
  - Each handshake also updates the running per-channel min/max (R5, G6, B5) over opaque texels.
  - The 16th handshake moves the state to ENCODE; count wraps to 0.
- Endpoints:
  - Opaque block: color0 = {Rmax,Gmax,Bmax}, color1 = {Rmin,Gmin,Bmin}.
  - This guarantees color0 > color1 unless all colors are equal.
  - If color0 == color1, force every index to 0.
- Palette: entries use the decoder's exact integer formulas.
  - 4-color: C0, C1, (2C0+C1+1)/3, (C0+2C1+1)/3.
  - 3-color: C0, C1, (C0+C1+1)/2, transparent.
- ENCODE:
  - One texel per cycle, t = 0..15.
  - Cost per candidate: 2|dR| + |dG| + 2|dB|, unsigned; R and B are weighted to 6-bit scale. 8-bit cost accumulator.
  - Select the minimum cost; ties go to the lowest index.
  - Write the result into the index register at bits [2t+1:2t].
- OUT:
  - block_valid = 1; bc1_data is held stable until the block_valid & block_ready handshake.
  - After the handshake, go to LOAD; clear min/max to (min=all-ones, max=0).
- texel_valid is ignored outside LOAD. block_ready is ignored outside OUT.

## Timing
- Reset values: texel_ready=0, block_valid=0, bc1_data=0, state=LOAD, count=0, min=all-ones, max=0.
- texel_ready is registered and rises on the first clk edge after rst deasserts.
- Throughput: one texel per cycle in LOAD.
- If the 16th texel handshake occurs at edge E:
  - texel_ready = 0 from E.
  - ENCODE occupies edges E+1..E+16.
  - block_valid = 1 after edge E+16 (latency 16 cycles).
- After the block handshake at edge H, texel_ready = 1 after edge H+1; there is no LOAD/OUT overlap.
- Minimum block period: 16 + 16 + 1 + 1 = 34 cycles.
- Reset mid-operation (any state): immediate return to reset values; the partial block is discarded, with no output.

## Configuration
- `TEXTURE_BC1_ENC_ALPHA_EN` defined:
  - A texel with A2[1]=0 is transparent and is excluded from min/max.
  - If any texel in the block is transparent, use 3-color mode: color0 = min, color1 = max (color0 ≤ color1). Transparent texels get index 3; opaque texels choose among indices 0..2.
  - If all texels are transparent: color0 = color1 = 0, all indices 3.
  - A block with no transparent texels encodes as opaque.
- Not defined: A2 is ignored; every block uses the opaque path. The alpha-detect and 3-color logic is not compiled.

## Test plan
- All 16 texels 0xF800/A2=11 → bc1_data = 0x00000000_F800_F800.
- Texels alternate 0x0000 (even t) and 0xFFFF (odd t), A2=11 → bc1_data = 0x11111111_0000_FFFF.
- t0=0xFFFF, t1=0x0000, t2=0x52AA (R10,G21,B10), rest 0xFFFF → bc1_data = 0x00000034_0000_FFFF (t2 maps to index 3).
- t0=0x0000/A2=11, t5=0xFFFF/A2=00, rest 0xFFFF/A2=11:
  - with macro → 0x55555D54_FFFF_0000.
  - without macro → 0x00000001_0000_FFFF.
- Backpressure: hold block_ready=0 for 10 cycles → block_valid stays 1, bc1_data is stable, and texel_ready stays 0. Then accept the block and check latency E→block_valid = 16 cycles.
- Assert rst after 7 texels, then feed a new block of 16 texels (case 1) → output equals case 1 exactly; no stale texels.

Source files
------------

// File: rtl/texture_bc1_enc_if.sv
// Texel-in / block-out stream bundle for the BC1 encoder.
// master = producer of texels and consumer of blocks; slave = the encoder.
interface texture_bc1_enc_if;
  logic        texel_valid;
  logic        texel_ready;
  logic [17:0] texel_rgba5652;
  logic        block_valid;
  logic        block_ready;
  logic [63:0] bc1_data;

  modport master (
    output texel_valid, texel_rgba5652, block_ready,
    input  texel_ready, block_valid, bc1_data
  );

  modport slave (
    input  texel_valid, texel_rgba5652, block_ready,
    output texel_ready, block_valid, bc1_data
  );
endinterface

// File: rtl/texture_bc1_enc.sv
// BC1 block encoder: 16 texels in, one 64-bit block out 16 cycles after the last texel; no texel
// is accepted until the block handshakes. TEXTURE_BC1_ENC_ALPHA_EN enables 3-color/transparent blocks.
module texture_bc1_enc (
  input  logic               clk,
  input  logic               rst,
  texture_bc1_enc_if.slave   bus
);
  typedef enum logic [1:0] {LOAD, ENCODE, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt;
  logic        texel_ready_q, block_valid_q;
  logic [63:0] bc1_data_q;
  logic [31:0] idx_q, idx_d;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic [15:0] tex_buf [16];
  logic [15:0] cur, c0, c1;
  logic [15:0] pal [4];
  logic [7:0]  best, cst;
  logic [1:0]  sel, lim;
  logic        load_hs, blk_hs, last, opaque_in;
  logic        unused_alpha;

  assign bus.texel_ready = texel_ready_q;
  assign bus.block_valid = block_valid_q;
  assign bus.bc1_data    = bc1_data_q;
  assign unused_alpha    = ^bus.texel_rgba5652[1:0];

  function automatic logic [5:0] absd(input logic [5:0] a, input logic [5:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [5:0] mix3(input logic [5:0] a, input logic [5:0] b);
    logic [7:0] s;
    s = {1'b0, a, 1'b0} + {2'b0, b} + 8'd1;
    return 6'(s / 8'd3);
  endfunction

  function automatic logic [5:0] mix2(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b} + 7'd1;
    return 6'(s >> 1);
  endfunction

  // (2a+b+1)/3 per channel, matching the decoder's integer rounding
  function automatic logic [15:0] pal3(input logic [15:0] a, input logic [15:0] b);
    return {5'(mix3({1'b0, a[15:11]}, {1'b0, b[15:11]})),
            mix3(a[10:5], b[10:5]),
            5'(mix3({1'b0, a[4:0]}, {1'b0, b[4:0]}))};
  endfunction

  function automatic logic [15:0] pal2(input logic [15:0] a, input logic [15:0] b);
    return {5'(mix2({1'b0, a[15:11]}, {1'b0, b[15:11]})),
            mix2(a[10:5], b[10:5]),
            5'(mix2({1'b0, a[4:0]}, {1'b0, b[4:0]}))};
  endfunction

  // R and B doubled so all three channels weigh in on a 6-bit scale
  function automatic logic [7:0] texel_cost(input logic [15:0] a, input logic [15:0] b);
    logic [5:0] dr, dg, db;
    dr = absd({1'b0, a[15:11]}, {1'b0, b[15:11]});
    dg = absd(a[10:5], b[10:5]);
    db = absd({1'b0, a[4:0]}, {1'b0, b[4:0]});
    return {1'b0, dr, 1'b0} + {2'b0, dg} + {1'b0, db, 1'b0};
  endfunction

`ifdef TEXTURE_BC1_ENC_ALPHA_EN
  logic [15:0] transp_buf;
  logic        any_transp, opaque_seen;
  assign opaque_in = bus.texel_rgba5652[1];
  always_comb begin
    c0 = {r_max, g_max, b_max};
    c1 = {r_min, g_min, b_min};
    if (!opaque_seen) begin
      c0 = '0;
      c1 = '0;
    end else if (any_transp) begin
      c0 = {r_min, g_min, b_min};
      c1 = {r_max, g_max, b_max};
    end
  end
`else
  assign opaque_in = 1'b1;
  assign c0 = {r_max, g_max, b_max};
  assign c1 = {r_min, g_min, b_min};
`endif

  always_comb begin
    state_d = state_q;
    last    = (cnt == 4'd15);
    load_hs = 1'b0;
    blk_hs  = 1'b0;
    case (state_q)
      LOAD: begin
        load_hs = bus.texel_valid & texel_ready_q;
        if (load_hs && last) state_d = ENCODE;
      end
      ENCODE: if (last) state_d = OUT;
      OUT: begin
        blk_hs = block_valid_q & bus.block_ready;
        if (blk_hs) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    cur    = tex_buf[cnt];
    pal[0] = c0;
    pal[1] = c1;
    pal[2] = pal3(c0, c1);
    pal[3] = pal3(c1, c0);
    lim    = 2'd3;
`ifdef TEXTURE_BC1_ENC_ALPHA_EN
    if (any_transp) begin
      pal[2] = pal2(c0, c1);
      lim    = 2'd2;
    end
`endif
    sel  = 2'd0;
    best = texel_cost(cur, pal[0]);
    cst  = '0;
    for (int i = 1; i < 4; i++) begin
      cst = texel_cost(cur, pal[i]);
      if (2'(i) <= lim && cst < best) begin
        best = cst;
        sel  = 2'(i);
      end
    end
`ifdef TEXTURE_BC1_ENC_ALPHA_EN
    if (any_transp) begin
      if (transp_buf[cnt]) sel = 2'd3;
    end else if (c0 == c1) begin
      sel = 2'd0;
    end
`else
    if (c0 == c1) sel = 2'd0;
`endif
    idx_d = idx_q;
    idx_d[{cnt, 1'b0} +: 2] = sel;
  end

  always_ff @(posedge clk) begin
    if (load_hs) tex_buf[cnt] <= bus.texel_rgba5652[17:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt           <= '0;
      texel_ready_q <= 1'b0;
      block_valid_q <= 1'b0;
      bc1_data_q    <= '0;
      idx_q         <= '0;
      {r_min, g_min, b_min} <= '1;
      {r_max, g_max, b_max} <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          texel_ready_q <= !(load_hs && last);
          if (load_hs) begin
            cnt <= cnt + 4'd1;
            if (opaque_in) begin
              if (bus.texel_rgba5652[17:13] < r_min) r_min <= bus.texel_rgba5652[17:13];
              if (bus.texel_rgba5652[17:13] > r_max) r_max <= bus.texel_rgba5652[17:13];
              if (bus.texel_rgba5652[12:7]  < g_min) g_min <= bus.texel_rgba5652[12:7];
              if (bus.texel_rgba5652[12:7]  > g_max) g_max <= bus.texel_rgba5652[12:7];
              if (bus.texel_rgba5652[6:2]   < b_min) b_min <= bus.texel_rgba5652[6:2];
              if (bus.texel_rgba5652[6:2]   > b_max) b_max <= bus.texel_rgba5652[6:2];
            end
          end
        end
        ENCODE: begin
          cnt   <= cnt + 4'd1;
          idx_q <= idx_d;
          if (last) begin
            block_valid_q <= 1'b1;
            bc1_data_q    <= {idx_d, c1, c0};
          end
        end
        OUT: begin
          if (blk_hs) begin
            block_valid_q <= 1'b0;
            {r_min, g_min, b_min} <= '1;
            {r_max, g_max, b_max} <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TEXTURE_BC1_ENC_ALPHA_EN
  always_ff @(posedge clk) begin
    if (load_hs) transp_buf[cnt] <= !bus.texel_rgba5652[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_transp  <= 1'b0;
      opaque_seen <= 1'b0;
    end else if (load_hs) begin
      if (cnt == 4'd0) begin
        any_transp  <= !bus.texel_rgba5652[1];
        opaque_seen <= bus.texel_rgba5652[1];
      end else begin
        any_transp  <= any_transp | !bus.texel_rgba5652[1];
        opaque_seen <= opaque_seen | bus.texel_rgba5652[1];
      end
    end
  end
`endif
endmodule

// File: tb/tb_texture_bc1_enc.sv
// Directed-vector bench for texture_bc1_enc: block contents, latency, backpressure, mid-block reset.
module tb_texture_bc1_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  texture_bc1_enc_if bus ();

  texture_bc1_enc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0][17:0] tex;
    logic [63:0]       exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_texels(input vec_t v, input int n);
    int g;
    for (int t = 0; t < n; t++) begin
      bus.texel_valid    = 1'b1;
      bus.texel_rgba5652 = v.tex[t];
      g = 0;
      while (!bus.texel_ready && g < 60) begin
        @(posedge clk); #1;
        g++;
      end
      if (!bus.texel_ready) begin
        check("texel_ready_timeout", 64'(bus.texel_ready), 64'd1);
        bus.texel_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.texel_valid = 1'b0;
  endtask

  // Sends a full block, then checks latency and contents; leaves the block pending.
  task automatic send_and_wait(input vec_t v, input string nm);
    int e;
    send_texels(v, 16);
    e = cyc;
    check({nm, "_ready_low_after_last"}, 64'(bus.texel_ready), 64'd0);
    while (!bus.block_valid && (cyc - e) < 40) begin
      @(posedge clk); #1;
    end
    check({nm, "_latency"}, 64'(cyc - e), 64'd16);
    check({nm, "_data"}, bus.bc1_data, v.exp);
  endtask

  task automatic accept_block(input string nm);
    bus.block_ready = 1'b1;
    @(posedge clk); #1;
    bus.block_ready = 1'b0;
    check({nm, "_valid_drop"}, 64'(bus.block_valid), 64'd0);
    check({nm, "_ready_h"}, 64'(bus.texel_ready), 64'd0);
    @(posedge clk); #1;
    check({nm, "_ready_h1"}, 64'(bus.texel_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    logic        stable_ok, valid_ok, tr_ok;

    bus.texel_valid    = 1'b0;
    bus.texel_rgba5652 = '0;
    bus.block_ready    = 1'b0;

    for (int t = 0; t < 16; t++) begin
      vecs[0].tex[t] = {16'hF800, 2'b11};
      vecs[1].tex[t] = (t % 2 == 0) ? {16'h0000, 2'b11} : {16'hFFFF, 2'b11};
      vecs[2].tex[t] = {16'hFFFF, 2'b11};
      vecs[3].tex[t] = {16'hFFFF, 2'b11};
      vecs[4].tex[t] = (t % 2 == 0) ? {16'h001F, 2'b11} : {16'h0000, 2'b11};
      vecs[5].tex[t] = {16'h1234, 2'b00};
    end
    vecs[2].tex[1] = {16'h0000, 2'b11};
    vecs[2].tex[2] = {16'h52AA, 2'b11};
    vecs[3].tex[0] = {16'h0000, 2'b11};
    vecs[3].tex[5] = {16'hFFFF, 2'b00};
    vecs[0].exp = 64'h00000000_F800_F800;
    vecs[1].exp = 64'h11111111_0000_FFFF;
    vecs[2].exp = 64'h00000034_0000_FFFF;
    vecs[4].exp = 64'h44444444_0000_001F;
`ifdef TEXTURE_BC1_ENC_ALPHA_EN
    vecs[3].exp = 64'h55555D54_FFFF_0000;
    vecs[5].exp = 64'hFFFFFFFF_0000_0000;
`else
    vecs[3].exp = 64'h00000001_0000_FFFF;
    vecs[5].exp = 64'h00000000_1234_1234;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_texel_ready", 64'(bus.texel_ready), 64'd0);
    check("reset_block_valid", 64'(bus.block_valid), 64'd0);
    check("reset_bc1_data", bus.bc1_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(bus.texel_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      send_and_wait(vecs[i], $sformatf("vec%0d", i));
      accept_block($sformatf("vec%0d", i));
    end

    // Backpressure: block must hold while block_ready stays low
    send_and_wait(vecs[1], "bp");
    held = bus.bc1_data;
    stable_ok = 1'b1;
    valid_ok  = 1'b1;
    tr_ok     = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.bc1_data !== held) stable_ok = 1'b0;
      if (bus.block_valid !== 1'b1) valid_ok = 1'b0;
      if (bus.texel_ready !== 1'b0) tr_ok = 1'b0;
    end
    check("bp_data_stable", 64'(stable_ok), 64'd1);
    check("bp_valid_held", 64'(valid_ok), 64'd1);
    check("bp_ready_low", 64'(tr_ok), 64'd1);
    check("bp_data", bus.bc1_data, vecs[1].exp);
    accept_block("bp");

    // Reset after 7 texels of a different color; the next block must not see them
    send_texels(vecs[4], 7);
    #3 rst = 1'b1;
    #1;
    check("midrst_texel_ready", 64'(bus.texel_ready), 64'd0);
    check("midrst_block_valid", 64'(bus.block_valid), 64'd0);
    check("midrst_bc1_data", bus.bc1_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_back", 64'(bus.texel_ready), 64'd1);
    send_and_wait(vecs[0], "post_rst");
    accept_block("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
